// File: rtl/m_display_anode_scan.sv
// m_display_anode_scan: tick-driven 4-digit common-anode 7-segment scanner with blanking gap and per-frame data latch
module m_display_anode_scan #(
  parameter logic [7:0] BLANK_CYCLES = 8'd4,
  parameter bit         LZ_SUPPRESS  = 1'b1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iCE,
  input  logic        iTick,
  input  logic [15:0] ivData,
  input  logic [3:0]  ivDp,
  input  logic [3:0]  ivDigitEn,
  output logic [3:0]  ovAnode,
  output logic [6:0]  ovSeg,
  output logic        oDp
);
  typedef enum logic {BLANK, SHOW} state_t;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [3:0]  dp_q, dp_d, en_q, en_d;
  logic [3:0]  anode_q, anode_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;
  logic        cap, lz, lit;
  logic [3:0]  nib;
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= BLANK;
      idx_q   <= 2'd3;
      cnt_q   <= 8'd0;
      data_q  <= 16'd0;
      dp_q    <= 4'd0;
      en_q    <= 4'd0;
      anode_q <= 4'hF;
      seg_q   <= 7'h7F;
      dpo_q   <= 1'b1;
    end else if (iCE) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dp_q    <= dp_d;
      en_q    <= en_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dpo_q   <= dpo_d;
    end
  end
  always_comb begin
    idx_d   = iTick ? idx_q + 2'd1 : idx_q;
    state_d = iTick ? BLANK : (state_q == BLANK && cnt_q == 8'd0) ? SHOW : state_q;
    cnt_d   = iTick ? BLANK_CYCLES : (state_q == BLANK && cnt_q != 8'd0) ? cnt_q - 8'd1 : cnt_q;
    cap     = iTick && idx_d == 2'd0;
    data_d  = cap ? ivData : data_q;
    dp_d    = cap ? ivDp : dp_q;
    en_d    = cap ? ivDigitEn : en_q;
  end
  // outputs can only light when no tick is present, so idx/shadow _q equal their _d values
  always_comb begin
    nib     = data_q[{idx_q, 2'b00} +: 4];
    lz      = LZ_SUPPRESS && idx_q != 2'd0 && (data_q >> {idx_q, 2'b00}) == 16'd0;
    lit     = state_d == SHOW && en_q[idx_q] && !lz;
    anode_d = lit ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d   = lit ? SEG_LUT[nib] : 7'h7F;
    dpo_d   = lit ? ~dp_q[idx_q] : 1'b1;
  end
  assign ovAnode = anode_q;
  assign ovSeg   = seg_q;
  assign oDp     = dpo_q;
endmodule

// File: tb/tb_m_display_anode_scan.sv
// tb_m_display_anode_scan: directed stimulus with a queue scoreboard popped by a tick-tracking monitor
module tb_m_display_anode_scan;
  localparam int B = 2;
  localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};
  logic        iClk = 1'b0, iReset = 1'b1, iCE = 1'b1, iTick = 1'b0;
  logic [15:0] ivData = 16'h0;
  logic [3:0]  ivDp = 4'h0, ivDigitEn = 4'hF;
  logic [3:0]  ovAnode;
  logic [6:0]  ovSeg;
  logic        oDp;
  int n_checks = 0, n_fail = 0;
  logic [11:0] sb [$];
  m_display_anode_scan #(.BLANK_CYCLES(8'(B)), .LZ_SUPPRESS(1'b1)) dut (
    .iClk(iClk), .iReset(iReset), .iCE(iCE), .iTick(iTick), .ivData(ivData),
    .ivDp(ivDp), .ivDigitEn(ivDigitEn), .ovAnode(ovAnode), .ovSeg(ovSeg), .oDp(oDp)
  );
  always #5 iClk = ~iClk;
  function automatic logic [11:0] outs();
    return {ovAnode, ovSeg, oDp};
  endfunction
  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got anode=%b seg=%h dp=%b, expected anode=%b seg=%h dp=%b",
               name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
    end
  endtask
  // monitor: tracks ticks itself and pops the scoreboard when a digit should appear
  int cd = -1;
  always @(posedge iClk) begin
    logic r, c, t;
    r = iReset; c = iCE; t = iTick;
    @(negedge iClk);
    if (r) begin
      cd = -1;
      chk("reset_off", outs(), OFF);
    end else if (c) begin
      if (t) begin
        cd = B;
        chk("tick_blank", outs(), OFF);
      end else if (cd > 0) begin
        cd--;
        chk("gap_blank", outs(), OFF);
      end else if (cd == 0) begin
        cd = -1;
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL sb_empty: digit appeared with no expected entry");
        end else chk("digit", outs(), sb.pop_front());
      end
    end
  end
  task automatic tick(input logic [3:0] an, input logic [6:0] sg, input logic dp);
    sb.push_back({an, sg, dp});
    @(negedge iClk) iTick = 1'b1;
    @(negedge iClk) iTick = 1'b0;
    repeat (18) @(negedge iClk);
  endtask
  initial begin
    repeat (3) @(negedge iClk);
    iReset = 1'b0;
    ivData = 16'h12AF;
    repeat (10) @(negedge iClk);
    chk("dark_before_first_tick", outs(), OFF);
    tick(4'b1110, 7'h0E, 1'b1);
    tick(4'b1101, 7'h08, 1'b1);
    tick(4'b1011, 7'h24, 1'b1);
    tick(4'b0111, 7'h79, 1'b1);
    ivData = 16'h0005;
    tick(4'b1110, 7'h12, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    ivData = 16'h0000;
    tick(4'b1110, 7'h40, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    ivData = 16'h1111;
    tick(4'b1110, 7'h79, 1'b1);
    tick(4'b1101, 7'h79, 1'b1);
    tick(4'b1011, 7'h79, 1'b1);
    ivData = 16'h2222;
    tick(4'b0111, 7'h79, 1'b1);
    tick(4'b1110, 7'h24, 1'b1);
    tick(4'b1101, 7'h24, 1'b1);
    tick(4'b1011, 7'h24, 1'b1);
    tick(4'b0111, 7'h24, 1'b1);
    ivDp = 4'b0110; ivDigitEn = 4'b1101;
    tick(4'b1110, 7'h24, 1'b1);
    tick(4'hF, 7'h7F, 1'b1);
    tick(4'b1011, 7'h24, 1'b0);
    tick(4'b0111, 7'h24, 1'b1);
    tick(4'b1110, 7'h24, 1'b1);
    // tick while disabled is dropped and outputs freeze
    @(negedge iClk) begin iCE = 1'b0; iTick = 1'b1; end
    @(negedge iClk) iTick = 1'b0;
    chk("ce_freeze", outs(), {4'b1110, 7'h24, 1'b1});
    repeat (3) @(negedge iClk);
    iCE = 1'b1;
    repeat (6) @(negedge iClk);
    chk("ce_tick_ignored", outs(), {4'b1110, 7'h24, 1'b1});
    // back-to-back ticks skip digit 1 and restart blanking for digit 2
    sb.push_back({4'b1011, 7'h24, 1'b0});
    @(negedge iClk) iTick = 1'b1;
    @(negedge iClk) iTick = 1'b1;
    @(negedge iClk) iTick = 1'b0;
    repeat (10) @(negedge iClk);
    @(negedge iClk) iReset = 1'b1;
    @(negedge iClk) iReset = 1'b0;
    repeat (5) @(negedge iClk);
    chk("dark_after_reset", outs(), OFF);
    tick(4'b1110, 7'h24, 1'b1);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
